// File: rtl/score_pkg.sv
// Shared constants and scanner state encoding for the score subsystem
// (scanner, score controller and RAM wrapper all import this package).
package score_pkg;

  localparam int NUM_USERS = 8;
  localparam int ADDR_W    = 3;
  localparam int DATA_W    = 6;
  localparam int RD_LAT    = 1;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    SCAN,
    DRAIN,
    DONE
  } scan_state_t;

endpackage

// File: rtl/score_max_tracker.sv
// Running maximum tracker: keeps best score, lowest owning id and a tie flag
// over a stream of tagged samples. Outputs show the value including this cycle's sample.
module score_max_tracker
  import score_pkg::*;
(
  input  logic              clock,
  input  logic              rst,
  input  logic              i_valid,
  input  logic [ADDR_W-1:0] i_tag,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_clear,
  output logic [DATA_W-1:0] o_best,
  output logic [ADDR_W-1:0] o_bestId,
  output logic              o_tie
);

  logic [DATA_W-1:0] r_best;
  logic [ADDR_W-1:0] r_bestId;
  logic              r_tie;

  logic [DATA_W-1:0] w_best;
  logic [ADDR_W-1:0] w_bestId;
  logic              w_tie;

  // Strict-greater update keeps the lowest id on ties; equal zero scores never count as a tie.
  always_comb begin
    w_best   = r_best;
    w_bestId = r_bestId;
    w_tie    = r_tie;
    if (i_clear) begin
      w_best   = '0;
      w_bestId = '0;
      w_tie    = 1'b0;
    end else if (i_valid) begin
      if (i_data > r_best) begin
        w_best   = i_data;
        w_bestId = i_tag;
        w_tie    = 1'b0;
      end else if ((i_data == r_best) && (i_data != '0)) begin
        w_tie = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      r_best   <= '0;
      r_bestId <= '0;
      r_tie    <= 1'b0;
    end else begin
      r_best   <= w_best;
      r_bestId <= w_bestId;
      r_tie    <= w_tie;
    end
  end

  assign o_best   = w_best;
  assign o_bestId = w_bestId;
  assign o_tie    = w_tie;

endmodule

// File: rtl/score_board_scanner.sv
// Sweeps the shared score RAM under request/grant and publishes max score, owner id and tie.
// Optional macro SCAN_NONZERO_COUNT_EN adds active_count (ids with a nonzero score).
module score_board_scanner
  import score_pkg::*;
(
  input  logic              clock,
  input  logic              rst,
  input  logic              scan_start,
  input  logic              rd_gnt,
  input  logic [DATA_W-1:0] ram_q,
  output logic              rd_req,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] max_score,
  output logic [ADDR_W-1:0] max_id,
  output logic              tie
`ifdef SCAN_NONZERO_COUNT_EN
  ,
  output logic [ADDR_W:0]   active_count
`endif
);

  localparam int DRAIN_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [DRAIN_W-1:0] LAST_DRAIN = DRAIN_W'(RD_LAT - 1);
  localparam logic [ADDR_W-1:0]  LAST_ADDR  = ADDR_W'(NUM_USERS - 1);

  scan_state_t r_state;
  scan_state_t w_nextState;

  logic [ADDR_W-1:0]  r_addr;
  logic [DRAIN_W-1:0] r_drainCnt;
  logic [RD_LAT-1:0]  r_vldPipe;
  logic [ADDR_W-1:0]  r_tagPipe [RD_LAT];

  logic w_issue;
  logic w_abort;
  logic w_clear;
  logic w_publish;
  logic w_sampleVld;
  logic [ADDR_W-1:0] w_sampleTag;

  logic [DATA_W-1:0] w_best;
  logic [ADDR_W-1:0] w_bestId;
  logic              w_tie;

  assign w_issue     = (r_state == SCAN) && rd_gnt;
  assign w_abort     = (r_state == SCAN) && !rd_gnt;
  assign w_clear     = (r_state == IDLE) || w_abort;
  assign w_publish   = (r_state == DRAIN) && (r_drainCnt == LAST_DRAIN);
  assign w_sampleVld = r_vldPipe[RD_LAT-1];
  assign w_sampleTag = r_tagPipe[RD_LAT-1];

  always_ff @(posedge clock) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Losing grant mid-sweep throws the partial sweep away and re-requests the port.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (scan_start) w_nextState = REQ;
      REQ:     if (rd_gnt) w_nextState = SCAN;
      SCAN: begin
        if (!rd_gnt) begin
          w_nextState = REQ;
        end else if (r_addr == LAST_ADDR) begin
          w_nextState = DRAIN;
        end
      end
      DRAIN:   if (r_drainCnt == LAST_DRAIN) w_nextState = DONE;
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      r_addr     <= '0;
      r_drainCnt <= '0;
    end else begin
      if ((r_state == REQ) && rd_gnt) begin
        r_addr <= '0;
      end else if (w_issue && (r_addr != LAST_ADDR)) begin
        r_addr <= r_addr + ADDR_W'(1);
      end
      if (r_state == DRAIN) begin
        r_drainCnt <= r_drainCnt + DRAIN_W'(1);
      end else begin
        r_drainCnt <= '0;
      end
    end
  end

  // Tags each issued address so the returning ram_q sample is credited to the right id.
  always_ff @(posedge clock) begin
    if (rst) begin
      r_vldPipe <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        r_tagPipe[i] <= '0;
      end
    end else begin
      r_vldPipe[0] <= w_issue;
      r_tagPipe[0] <= r_addr;
      for (int i = 1; i < RD_LAT; i++) begin
        r_vldPipe[i] <= r_vldPipe[i-1];
        r_tagPipe[i] <= r_tagPipe[i-1];
      end
      if (w_abort) begin
        r_vldPipe <= '0;
      end
    end
  end

  score_max_tracker u_tracker (
    .clock    (clock),
    .rst      (rst),
    .i_valid  (w_sampleVld),
    .i_tag    (w_sampleTag),
    .i_data   (ram_q),
    .i_clear  (w_clear),
    .o_best   (w_best),
    .o_bestId (w_bestId),
    .o_tie    (w_tie)
  );

  // Results load on the edge into DONE so they are already valid while done is high.
  always_ff @(posedge clock) begin
    if (rst) begin
      max_score <= '0;
      max_id    <= '0;
      tie       <= 1'b0;
    end else if (w_publish) begin
      max_score <= w_best;
      max_id    <= w_bestId;
      tie       <= w_tie;
    end
  end

`ifdef SCAN_NONZERO_COUNT_EN
  logic [ADDR_W:0] r_cnt;
  logic [ADDR_W:0] w_cntNext;

  always_comb begin
    w_cntNext = r_cnt;
    if (w_clear) begin
      w_cntNext = '0;
    end else if (w_sampleVld && (ram_q != '0)) begin
      w_cntNext = r_cnt + (ADDR_W+1)'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      r_cnt        <= '0;
      active_count <= '0;
    end else begin
      r_cnt <= w_cntNext;
      if (w_publish) begin
        active_count <= w_cntNext;
      end
    end
  end
`endif

  assign rd_req   = (r_state == REQ) || (r_state == SCAN);
  assign busy     = (r_state == REQ) || (r_state == SCAN) || (r_state == DRAIN);
  assign done     = (r_state == DONE);
  assign ram_addr = r_addr;

endmodule

// File: tb/tb_score_board_scanner.sv
// Directed self-checking bench for score_board_scanner with a one-cycle-latency RAM model.
module tb_score_board_scanner;

  logic       clock = 1'b0;
  logic       rst;
  logic       scan_start;
  logic       rd_gnt;
  logic [5:0] ram_q;
  logic       rd_req;
  logic [2:0] ram_addr;
  logic       busy;
  logic       done;
  logic [5:0] max_score;
  logic [2:0] max_id;
  logic       tie;
`ifdef SCAN_NONZERO_COUNT_EN
  logic [3:0] active_count;
`endif

  logic [5:0] mem [8];

  int assertCount = 0;
  int failCount   = 0;

  int   sweepDoneCycle;
  int   sweepDoneCount;
  bit   sweepBusyOk;
  bit   sweepHoldOk;
  logic [5:0] capMax;
  logic [2:0] capId;
  logic       capTie;
  logic [3:0] capCnt;

  score_board_scanner dut (
    .clock      (clock),
    .rst        (rst),
    .scan_start (scan_start),
    .rd_gnt     (rd_gnt),
    .ram_q      (ram_q),
    .rd_req     (rd_req),
    .ram_addr   (ram_addr),
    .busy       (busy),
    .done       (done),
    .max_score  (max_score),
    .max_id     (max_id),
    .tie        (tie)
`ifdef SCAN_NONZERO_COUNT_EN
    ,
    .active_count (active_count)
`endif
  );

  always #5 clock = ~clock;

  // Single-port RAM read model: data for the address driven this cycle appears next cycle.
  always @(posedge clock) begin
    ram_q <= mem[ram_addr];
  end

  // Packed as {id7, id6, ..., id0}.
  task automatic loadScores(input logic [47:0] v);
    for (int i = 0; i < 8; i++) begin
      mem[i] = v[i*6 +: 6];
    end
  endtask

  function automatic logic [3:0] nonzeroCount();
    logic [3:0] n;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      if (mem[i] != 0) n = n + 1;
    end
    return n;
  endfunction

  // Runs one sweep from a scan_start pulse at cycle 0 and records what the DUT did.
  task automatic runSweep(input int gntLow, input bit dropAt4, input bit extraStarts);
    bit dropped;
    int dropLeft;
    logic [2:0] addr1;
    sweepDoneCycle = -1;
    sweepDoneCount = 0;
    sweepBusyOk    = 1;
    sweepHoldOk    = 1;
    dropped        = 0;
    dropLeft       = 0;
    addr1          = '0;
    capMax = '0; capId = '0; capTie = 1'b0; capCnt = '0;
    @(posedge clock); #1;
    scan_start = 1'b1;
    rd_gnt     = 1'b1;
    @(posedge clock); #1;
    scan_start = 1'b0;
    for (int k = 1; k <= 25; k++) begin
      if (k <= gntLow) begin
        rd_gnt = 1'b0;
      end else if (dropLeft > 0) begin
        rd_gnt = 1'b0;
        dropLeft--;
      end else begin
        rd_gnt = 1'b1;
      end
      scan_start = extraStarts && ((k == 3) || (k == 6));
      @(negedge clock);
      if (k == 1) addr1 = ram_addr;
      if ((k <= gntLow) && ((rd_req !== 1'b1) || (ram_addr !== addr1))) sweepHoldOk = 0;
      if (done === 1'b1) begin
        sweepDoneCount++;
        if (sweepDoneCycle < 0) begin
          sweepDoneCycle = k;
          capMax = max_score;
          capId  = max_id;
          capTie = tie;
`ifdef SCAN_NONZERO_COUNT_EN
          capCnt = active_count;
`endif
        end
      end
      if (busy !== (sweepDoneCycle < 0)) sweepBusyOk = 0;
      if (dropAt4 && !dropped && (rd_req === 1'b1) && (rd_gnt === 1'b1) && (ram_addr === 3'd4)) begin
        dropped  = 1;
        dropLeft = 2;
      end
      @(posedge clock); #1;
    end
    scan_start = 1'b0;
    rd_gnt     = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; scan_start = 1'b0; rd_gnt = 1'b1;
    repeat (2) @(posedge clock);
    #1 rst = 1'b0;
    @(negedge clock);
    assertCount++;
    if ({rd_req, busy, done, tie, max_score, max_id, ram_addr} !== 15'd0) begin
      failCount++;
      $display("[TB] FAIL reset_outputs: got rd_req=%b busy=%b done=%b tie=%b max=%0d id=%0d addr=%0d, required all 0",
               rd_req, busy, done, tie, max_score, max_id, ram_addr);
    end
`ifdef SCAN_NONZERO_COUNT_EN
    assertCount++;
    if (active_count !== 4'd0) begin
      failCount++;
      $display("[TB] FAIL reset_active_count: got %0d required 0", active_count);
    end
`endif
  endtask

  task automatic test_basic();
    loadScores({6'd9, 6'd22, 6'd0, 6'd7, 6'd40, 6'd3, 6'd12, 6'd5});
    runSweep(0, 0, 0);
    assertCount++;
    if (sweepDoneCycle !== 11) begin
      failCount++; $display("[TB] FAIL basic_done_cycle: got %0d required 11", sweepDoneCycle);
    end
    assertCount++;
    if (sweepDoneCount !== 1) begin
      failCount++; $display("[TB] FAIL basic_done_count: got %0d required 1", sweepDoneCount);
    end
    assertCount++;
    if (sweepBusyOk !== 1'b1) begin
      failCount++; $display("[TB] FAIL basic_busy_window: busy not high exactly cycles 1-10");
    end
    assertCount++;
    if ({capMax, capId, capTie} !== {6'd40, 3'd3, 1'b0}) begin
      failCount++; $display("[TB] FAIL basic_result: got max=%0d id=%0d tie=%b required 40/3/0", capMax, capId, capTie);
    end
    assertCount++;
    if ({max_score, max_id, tie} !== {6'd40, 3'd3, 1'b0}) begin
      failCount++; $display("[TB] FAIL basic_hold: got max=%0d id=%0d tie=%b required 40/3/0", max_score, max_id, tie);
    end
`ifdef SCAN_NONZERO_COUNT_EN
    assertCount++;
    if (capCnt !== nonzeroCount()) begin
      failCount++; $display("[TB] FAIL basic_active_count: got %0d required %0d", capCnt, nonzeroCount());
    end
`endif
  endtask

  task automatic test_tie();
    loadScores({6'd2, 6'd1, 6'd30, 6'd0, 6'd29, 6'd30, 6'd10, 6'd4});
    runSweep(0, 0, 0);
    assertCount++;
    if ({capMax, capId, capTie} !== {6'd30, 3'd2, 1'b1}) begin
      failCount++; $display("[TB] FAIL tie_result: got max=%0d id=%0d tie=%b required 30/2/1", capMax, capId, capTie);
    end
`ifdef SCAN_NONZERO_COUNT_EN
    assertCount++;
    if (capCnt !== 4'd7) begin
      failCount++; $display("[TB] FAIL tie_active_count: got %0d required 7", capCnt);
    end
`endif
  endtask

  task automatic test_tie_cleared();
    loadScores({6'd5, 6'd4, 6'd3, 6'd2, 6'd1, 6'd50, 6'd20, 6'd20});
    runSweep(0, 0, 0);
    assertCount++;
    if ({capMax, capId, capTie} !== {6'd50, 3'd2, 1'b0}) begin
      failCount++; $display("[TB] FAIL tie_cleared_result: got max=%0d id=%0d tie=%b required 50/2/0", capMax, capId, capTie);
    end
  endtask

  task automatic test_boundary();
    loadScores({6'd63, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0});
    runSweep(0, 0, 0);
    assertCount++;
    if ({capMax, capId, capTie} !== {6'd63, 3'd7, 1'b0}) begin
      failCount++; $display("[TB] FAIL boundary_result: got max=%0d id=%0d tie=%b required 63/7/0", capMax, capId, capTie);
    end
  endtask

  task automatic test_all_zero();
    loadScores(48'd0);
    runSweep(0, 0, 0);
    assertCount++;
    if ({capMax, capId, capTie} !== {6'd0, 3'd0, 1'b0}) begin
      failCount++; $display("[TB] FAIL zero_result: got max=%0d id=%0d tie=%b required 0/0/0", capMax, capId, capTie);
    end
    assertCount++;
    if (sweepDoneCycle !== 11) begin
      failCount++; $display("[TB] FAIL zero_done_cycle: got %0d required 11", sweepDoneCycle);
    end
`ifdef SCAN_NONZERO_COUNT_EN
    assertCount++;
    if (capCnt !== 4'd0) begin
      failCount++; $display("[TB] FAIL zero_active_count: got %0d required 0", capCnt);
    end
`endif
  endtask

  task automatic test_grant_wait();
    loadScores({6'd9, 6'd22, 6'd0, 6'd7, 6'd40, 6'd3, 6'd12, 6'd5});
    runSweep(4, 0, 0);
    assertCount++;
    if (sweepHoldOk !== 1'b1) begin
      failCount++; $display("[TB] FAIL grant_wait_hold: rd_req dropped or address moved while grant low");
    end
    assertCount++;
    if (sweepDoneCycle !== 15) begin
      failCount++; $display("[TB] FAIL grant_wait_done_cycle: got %0d required 15", sweepDoneCycle);
    end
    assertCount++;
    if ({capMax, capId, capTie} !== {6'd40, 3'd3, 1'b0}) begin
      failCount++; $display("[TB] FAIL grant_wait_result: got max=%0d id=%0d tie=%b required 40/3/0", capMax, capId, capTie);
    end
  endtask

  task automatic test_grant_drop();
    // A stale partial best would be re-seen after restart and raise tie falsely.
    loadScores({6'd5, 6'd4, 6'd3, 6'd2, 6'd1, 6'd50, 6'd20, 6'd20});
    runSweep(0, 1, 0);
    assertCount++;
    if (sweepDoneCycle !== 19) begin
      failCount++; $display("[TB] FAIL grant_drop_done_cycle: got %0d required 19", sweepDoneCycle);
    end
    assertCount++;
    if (sweepDoneCount !== 1) begin
      failCount++; $display("[TB] FAIL grant_drop_done_count: got %0d required 1", sweepDoneCount);
    end
    assertCount++;
    if ({capMax, capId, capTie} !== {6'd50, 3'd2, 1'b0}) begin
      failCount++; $display("[TB] FAIL grant_drop_result: got max=%0d id=%0d tie=%b required 50/2/0", capMax, capId, capTie);
    end
`ifdef SCAN_NONZERO_COUNT_EN
    assertCount++;
    if (capCnt !== 4'd8) begin
      failCount++; $display("[TB] FAIL grant_drop_active_count: got %0d required 8", capCnt);
    end
`endif
  endtask

  task automatic test_busy_ignore();
    loadScores({6'd9, 6'd22, 6'd0, 6'd7, 6'd40, 6'd3, 6'd12, 6'd5});
    runSweep(0, 0, 1);
    assertCount++;
    if (sweepDoneCount !== 1) begin
      failCount++; $display("[TB] FAIL busy_ignore_done_count: got %0d required 1", sweepDoneCount);
    end
    assertCount++;
    if ((sweepDoneCycle !== 11) || (sweepBusyOk !== 1'b1)) begin
      failCount++; $display("[TB] FAIL busy_ignore_timing: done cycle %0d busy_ok %b, required 11 and 1", sweepDoneCycle, sweepBusyOk);
    end
  endtask

  task automatic test_reset_mid_sweep();
    int dones;
    dones = 0;
    @(posedge clock); #1;
    scan_start = 1'b1;
    rd_gnt     = 1'b1;
    @(posedge clock); #1;
    for (int k = 1; k <= 4; k++) begin
      scan_start = (k == 3);
      @(negedge clock);
      if (k == 4) begin
        assertCount++;
        if ({max_score, max_id} !== {6'd40, 3'd3}) begin
          failCount++; $display("[TB] FAIL mid_sweep_hold: got max=%0d id=%0d required 40/3", max_score, max_id);
        end
      end
      @(posedge clock); #1;
    end
    scan_start = 1'b0;
    rst = 1'b1;
    @(posedge clock); #1;
    rst = 1'b0;
    @(negedge clock);
    assertCount++;
    if ({rd_req, busy, done, tie, max_score, max_id, ram_addr} !== 15'd0) begin
      failCount++;
      $display("[TB] FAIL mid_reset_outputs: got rd_req=%b busy=%b done=%b tie=%b max=%0d id=%0d addr=%0d, required all 0",
               rd_req, busy, done, tie, max_score, max_id, ram_addr);
    end
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if (done === 1'b1) dones++;
    end
    assertCount++;
    if (dones !== 0) begin
      failCount++; $display("[TB] FAIL mid_reset_no_done: got %0d done pulses required 0", dones);
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = '0;
    test_reset();
    test_basic();
    test_tie();
    test_tie_cleared();
    test_boundary();
    test_all_zero();
    test_grant_wait();
    test_grant_drop();
    test_busy_ignore();
    test_reset_mid_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
